// File: rtl/itcm_port_arbiter.sv
// Shares one single-port ITCM SRAM between the IFU fetch and LSU data channels.
// Build macro ITCM_ARB_RR_EN swaps LSU-first priority for round-robin arbitration.
module itcm_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic          lsu_req_write,
  input  logic [DW-1:0] lsu_req_wdata,
  input  logic [MW-1:0] lsu_req_wmask,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner;
  logic          r_is_wr;
  logic [DW-1:0] r_rdata;
  logic          w_rsp_hs;
  logic          w_window;
  logic          w_prio_lsu;
  logic          w_sel_lsu;
  logic          w_sel_ifu;
  logic          w_grant;

`ifdef ITCM_ARB_RR_EN
  logic r_last_grant;

  // Remembers the previous winner so contention alternates between requesters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= OWN_IFU;
    end else if (w_grant) begin
      r_last_grant <= w_sel_lsu;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign w_prio_lsu = (r_last_grant == OWN_IFU);
`else
  assign w_prio_lsu = 1'b1;
`endif

  // A new grant may overlap the cycle in which the current owner takes its response.
  assign w_rsp_hs  = (r_state == ST_RESP) &
                     ((r_owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready);
  assign w_window  = ~rst & ((r_state == ST_IDLE) | w_rsp_hs);
  assign w_sel_lsu = lsu_req_valid & (~ifu_req_valid | w_prio_lsu);
  assign w_sel_ifu = ifu_req_valid & ~w_sel_lsu;
  assign w_grant   = w_window & (w_sel_lsu | w_sel_ifu);

  assign lsu_req_ready = w_window & w_sel_lsu;
  assign ifu_req_ready = w_window & w_sel_ifu;

  // Next-state decode and SRAM command driven in the grant cycle.
  always_comb begin
    w_state_nxt = r_state;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_wem     = {MW{1'b0}};
    ram_addr    = ifu_req_addr;
    ram_din     = {DW{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = w_grant ? ST_ACCESS : ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_grant) begin
      ram_cs = 1'b1;
      if (w_sel_lsu) begin
        ram_addr = lsu_req_addr;
        ram_din  = lsu_req_wdata;
        ram_we   = lsu_req_write;
        ram_wem  = lsu_req_write ? lsu_req_wmask : {MW{1'b0}};
      end else begin
        ram_addr = ifu_req_addr;
      end
    end else begin
      ram_cs = 1'b0;
    end
  end

  // FSM state, transaction owner and the captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IFU;
      r_is_wr <= 1'b0;
      r_rdata <= {DW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner <= w_sel_lsu;
        r_is_wr <= w_sel_lsu & lsu_req_write;
      end else begin
        r_owner <= r_owner;
        r_is_wr <= r_is_wr;
      end
      if (r_state == ST_ACCESS) begin
        r_rdata <= r_is_wr ? {DW{1'b0}} : ram_dout;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  assign ifu_rsp_valid = (r_state == ST_RESP) & (r_owner == OWN_IFU);
  assign lsu_rsp_valid = (r_state == ST_RESP) & (r_owner == OWN_LSU);
  assign ifu_rsp_rdata = ifu_rsp_valid ? r_rdata : {DW{1'b0}};
  assign lsu_rsp_rdata = lsu_rsp_valid ? r_rdata : {DW{1'b0}};

endmodule
